serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial WIDTH-bit subtractor, the inverse companion of the team's
//  registered parallel adder. Computes Diff = A - B LSB-first, one bit per
//  clock, using a 1-bit full subtractor and a borrow flop.
//  Start/Busy/Done handshake. Sits beside the adder in the counter datapath,
//  where area matters more than latency.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2)
// PORTS
//  Clk     in   1      rising-edge clock; sole clock domain
//  Rst     in   1      reset, asynchronous, active-high
//  En      in   1      start request; sampled only in IDLE
//  A       in   WIDTH  minuend, captured on accepted start
//  B       in   WIDTH  subtrahend, captured on accepted start
//  Busy    out  1      high in SHIFT state
//  Done    out  1      one-cycle pulse when Diff/Borrow update
//  Diff    out  WIDTH  registered result, held until next Done
//  Borrow  out  1      registered borrow-out (1 => A < B unsigned)
// BEHAVIOUR
//  - Reset (async, Rst=1): state=IDLE; Busy=0, Done=0, Diff=0, Borrow=0;
//    operand shift regs, bit counter and borrow flop cleared. Takes effect
//    immediately, mid-operation included; the partial result is discarded.
//  - FSM states IDLE -> SHIFT -> DONE -> IDLE.
//    IDLE:  En=1 at edge: capture A,B; br=0; cnt=0; go SHIFT. Else stay.
//    SHIFT: per edge, on a0=a[0], b0=b[0]:
//             d   = a0 ^ b0 ^ br
//             br' = (~a0 & b0) | (~(a0 ^ b0) & br)
//           Shift a,b right by 1. Shift d into the MSB of the result
//           register. cnt++. After WIDTH shifts, go DONE.
//    DONE:  Diff <= result reg, Borrow <= br, Done=1 this cycle only.
//           Go IDLE.
//  - Latency: start accepted at edge k -> Done=1 and new Diff/Borrow
//    visible after edge k+WIDTH+1. Next start is accepted no earlier than
//    edge k+WIDTH+2.
//  - En while SHIFT or DONE: ignored, not queued. A/B changes after capture
//    have no effect.
//  - Diff/Borrow change only at DONE; they are stable between Done pulses.
//  - Arithmetic is unsigned, modulo 2^WIDTH. Borrow=1 iff A<B. A==B gives
//    Diff=0, Borrow=0.
//  - cnt width = $clog2(WIDTH+1). The counter never wraps; it resets on start.
// CONFIGURATION
//  SERIAL_SUB_SAT_EN defined: at DONE, if the final borrow is 1, Diff <= 0
//    (saturate at zero). Borrow is still reported as 1.
//  Not defined: Diff is the wrapped two's-complement result (e.g. 3-9 -> 0xA).
//  All other behaviour is identical in both builds.
// TESTING (WIDTH=4)
//  1. Rst=1, then release; no En -> Busy=0, Done=0, Diff=0, Borrow=0
//     indefinitely.
//  2. A=9,B=3, En pulse at edge k -> Busy high for 4 cycles, Done pulse
//     after edge k+5, Diff=6, Borrow=0.
//  3. A=3,B=9 -> Diff=0xA, Borrow=1. With SERIAL_SUB_SAT_EN: Diff=0,
//     Borrow=1.
//  4. A=15,B=15 -> Diff=0, Borrow=0. A=0,B=15 -> Diff=1, Borrow=1 (0 if SAT).
//  5. Start A=9,B=3; at SHIFT cycle 2 hold En=1 with A=1,B=2 -> ignored;
//     result Diff=6. Then En in IDLE with A=1,B=2 -> Diff=0xF, Borrow=1.
//  6. Rst pulse mid-SHIFT -> all outputs 0 immediately, FSM IDLE. A new
//     start afterwards yields the correct result with no residual borrow.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (Diff = A - B, LSB first) with a Start/Busy/Done handshake.
// Optional build macro SERIAL_SUB_SAT_EN: clamp Diff to zero when the final borrow is set.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             d, br_nxt;

  // One full-subtractor slice on the current LSBs.
  always_comb begin
    d      = a_sr[0] ^ b_sr[0] ^ br;
    br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  end

  assign Busy = (state == SHIFT);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      Done   <= 1'b0;
      Diff   <= '0;
      Borrow <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (En) begin
            a_sr  <= A;
            b_sr  <= B;
            br    <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d, res_sr[WIDTH-1:1]};
          br     <= br_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) state <= FIN;
        end
        FIN: begin
`ifdef SERIAL_SUB_SAT_EN
          Diff <= br ? '0 : res_sr;
`else
          Diff <= res_sr;
`endif
          Borrow <= br;
          Done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4); honours SERIAL_SUB_SAT_EN like the RTL.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             En  = 1'b0;
  logic [WIDTH-1:0] A   = '0;
  logic [WIDTH-1:0] B   = '0;
  logic             Busy, Done, Borrow;
  logic [WIDTH-1:0] Diff;

  int total = 0;
  int bad   = 0;

  logic [WIDTH:0] sb[$];      // {borrow, diff}
  logic [WIDTH:0] last_exp = '0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Diff(Diff), .Borrow(Borrow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] dv;
    logic             bw;
    bw = (a < b);
    dv = a - b;
`ifdef SERIAL_SUB_SAT_EN
    if (bw) dv = '0;
`endif
    return {bw, dv};
  endfunction

  // Pop and compare on every Done; outside Done the held result must match the last one.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (Done) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          last_exp = sb.pop_front();
          chk("diff", {28'd0, Diff}, {28'd0, last_exp[WIDTH-1:0]});
          chk("borrow", {31'd0, Borrow}, {31'd0, last_exp[WIDTH]});
        end
      end else begin
        chk("hold", {27'd0, Borrow, Diff}, {27'd0, last_exp});
      end
    end
  end

  task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge Clk);
    A = a; B = b; En = 1'b1;
    sb.push_back(model(a, b));
    @(posedge Clk);
    #1 En = 1'b0;
  endtask

  // Wait for Done from just after the start edge; returns cycles seen and Busy-high count.
  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0; busy_n = 0;
    do begin
      @(negedge Clk);
      cyc++;
      if (Busy) busy_n++;
    end while (!Done && cyc < 50);
    if (cyc >= 50) chk("timeout", 1, 0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int cyc, bn;
    start(a, b);
    wait_done(cyc, bn);
    chk("latency", cyc, WIDTH + 2);
    chk("busy_cycles", bn, WIDTH);
  endtask

  initial begin
    int cyc, bn;
    // 1. reset then idle
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("idle_out", {28'd0, Busy, Done, Borrow, 1'b0} | {27'd0, Diff, 1'b0} , 0);
    end

    // 2-4. main function and boundaries
    run_op(4'd9, 4'd3);
    run_op(4'd3, 4'd9);
    run_op(4'd15, 4'd15);
    run_op(4'd0, 4'd15);
    run_op(4'd15, 4'd0);
    run_op(4'd8, 4'd7);
    for (int i = 0; i < 6; i++) run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    // 5. En while busy is ignored
    start(4'd9, 4'd3);
    @(negedge Clk);
    A = 4'd1; B = 4'd2; En = 1'b1;
    repeat (3) @(posedge Clk);
    #1 En = 1'b0;
    wait_done(cyc, bn);
    chk("ignored_en_done", {31'd0, Done}, 1);
    @(negedge Clk);
    chk("no_restart", {31'd0, Busy}, 0);
    run_op(4'd1, 4'd2);

    // 6. reset mid-SHIFT, then clean restart
    start(4'd0, 4'd15);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    sb.delete();
    last_exp = '0;
    #1;
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_done", {31'd0, Done}, 0);
    chk("rst_diff", {28'd0, Diff}, 0);
    chk("rst_borrow", {31'd0, Borrow}, 0);
    @(posedge Clk);
    #1 Rst = 1'b0;
    run_op(4'd5, 4'd3);
    run_op(4'd7, 4'd7);

    repeat (3) @(negedge Clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
